// File: rtl/sramc_pkg.sv
// Shared SRAM controller package.
// Holds the arbiter state encoding and the HSIZE constants used by the SRAM
// controller, the arbiter and the write-enable decoder.
package sramc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic [2:0] BYTE = 3'b000;
  localparam logic [2:0] HALF = 3'b001;
  localparam logic [2:0] WORD = 3'b010;

endpackage

// File: rtl/sramc_arb_if.sv
// Requester-side bus of the SRAM access arbiter.
// Carries both ports' request fields, their combinational grants, the
// per-port read-valid pulses and the shared registered read data.
//   slave  modport : arbiter side (requests in, grant/rvalid/rdata out)
//   master modport : requester side (mirror of slave)
interface sramc_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  p0_req;
  logic                  p0_write;
  logic [2:0]            p0_size;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_gnt;
  logic                  p0_rvalid;

  logic                  p1_req;
  logic                  p1_write;
  logic [2:0]            p1_size;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_gnt;
  logic                  p1_rvalid;

  logic [DATA_WIDTH-1:0] rdata;

  modport slave (
    input  p0_req, p0_write, p0_size, p0_addr, p0_wdata,
    input  p1_req, p1_write, p1_size, p1_addr, p1_wdata,
    output p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, rdata
  );

  modport master (
    output p0_req, p0_write, p0_size, p0_addr, p0_wdata,
    output p1_req, p1_write, p1_size, p1_addr, p1_wdata,
    input  p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, rdata
  );
endinterface

// File: rtl/sramc_wen_dec.sv
// Byte write-enable decoder for the 32-bit SRAM.
// Ports:
//   write   in  1 : 1 = write transfer, 0 = read
//   size    in  3 : HSIZE encoding
//   addr_lo in  2 : byte offset within the word
//   wen     out 4 : active-low byte write enables (all high for reads)
module sramc_wen_dec
  import sramc_pkg::*;
(
  input  logic       write,
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wen
);

  logic [3:0] en;

  always_comb begin
    en = 4'b0000;
    if (write) begin
      if (size == BYTE)      en = 4'b0001 << addr_lo;
      else if (size == HALF) en = addr_lo[1] ? 4'b1100 : 4'b0011;
      else                   en = 4'b1111;
    end
    wen = ~en;
  end

endmodule

// File: rtl/sramc_arb.sv
// Two-port SRAM access arbiter.
// Shares one single-ported 32-bit SRAM between port 0 (AHB slave path) and
// port 1 (secondary master), issues registered SRAM strobes and returns read
// data to the port that issued the read.
// Optional feature macro: SRAMC_ARB_BURST_LIMIT_EN -- when defined, an owner
// is pre-empted after MAX_GNT consecutive transfers if the other port waits;
// otherwise the owner keeps the SRAM for as long as it requests.
// Ports:
//   hclk, hreset         : clock, synchronous active-high reset
//   bus (slave modport)  : p0/p1 requests, grants, rvalid pulses, rdata
//   sram_cen/wen/addr/wdata : registered SRAM strobes (active-low cen/wen)
//   sram_rdata           : SRAM read data, valid the cycle after a read strobe
module sramc_arb
  import sramc_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_GNT         = 4
) (
  input  logic                       hclk,
  input  logic                       hreset,
  sramc_arb_if.slave                 bus,
  output logic                       sram_cen,
  output logic [3:0]                 sram_wen,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0]      sram_wdata,
  input  logic [DATA_WIDTH-1:0]      sram_rdata
);

  arb_state_e state;
  logic       last_owner;
  logic       gnt0, gnt1;
  logic       xfer, switch_own, limit_hit;

`ifdef SRAMC_ARB_BURST_LIMIT_EN
  localparam logic [3:0] MAX_GNT_C = 4'(MAX_GNT);
  logic [3:0] gnt_cnt;
  assign limit_hit = (gnt_cnt == MAX_GNT_C);
`else
  logic unused_max_gnt;
  assign unused_max_gnt = ^4'(MAX_GNT);
  assign limit_hit      = 1'b0;
`endif

  // Upper address bits fall outside the SRAM and are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{bus.p0_addr[ADDR_WIDTH-1:SRAM_ADDR_WIDTH+2],
                            bus.p1_addr[ADDR_WIDTH-1:SRAM_ADDR_WIDTH+2]};

  // Grant selection: at most one port per cycle, blocked during reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!hreset) begin
      case (state)
        OWN0: begin
          if (bus.p0_req && !(limit_hit && bus.p1_req)) gnt0 = 1'b1;
          else if (bus.p1_req)                         gnt1 = 1'b1;
        end
        OWN1: begin
          if (bus.p1_req && !(limit_hit && bus.p0_req)) gnt1 = 1'b1;
          else if (bus.p0_req)                         gnt0 = 1'b1;
        end
        default: begin
          // From IDLE a tie goes to the port that did not own last.
          if (bus.p0_req && bus.p1_req) begin
            gnt0 = last_owner;
            gnt1 = !last_owner;
          end else begin
            gnt0 = bus.p0_req;
            gnt1 = bus.p1_req;
          end
        end
      endcase
    end
  end

  assign bus.p0_gnt = gnt0;
  assign bus.p1_gnt = gnt1;
  assign xfer       = gnt0 | gnt1;
  assign switch_own = ((state == OWN0) && gnt1) || ((state == OWN1) && gnt0);

  // Fields of the winning port.
  logic                       sel_write;
  logic [2:0]                 sel_size;
  logic [1:0]                 sel_lo;
  logic [SRAM_ADDR_WIDTH-1:0] sel_word;
  logic [DATA_WIDTH-1:0]      sel_wdata;
  logic [3:0]                 sel_wen;

  assign sel_write = gnt1 ? bus.p1_write : bus.p0_write;
  assign sel_size  = gnt1 ? bus.p1_size  : bus.p0_size;
  assign sel_lo    = gnt1 ? bus.p1_addr[1:0] : bus.p0_addr[1:0];
  assign sel_word  = gnt1 ? bus.p1_addr[SRAM_ADDR_WIDTH+1:2]
                          : bus.p0_addr[SRAM_ADDR_WIDTH+1:2];
  assign sel_wdata = gnt1 ? bus.p1_wdata : bus.p0_wdata;

  sramc_wen_dec u_wen_dec (
    .write   (sel_write),
    .size    (sel_size),
    .addr_lo (sel_lo),
    .wen     (sel_wen)
  );

  // Arbiter FSM.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
`ifdef SRAMC_ARB_BURST_LIMIT_EN
      gnt_cnt    <= 4'd0;
`endif
    end else begin
      if (!xfer) begin
        state <= IDLE;
      end else begin
        state      <= gnt1 ? OWN1 : OWN0;
        last_owner <= gnt1;
      end
`ifdef SRAMC_ARB_BURST_LIMIT_EN
      if (!xfer)                             gnt_cnt <= 4'd0;
      else if (state == IDLE || switch_own)  gnt_cnt <= 4'd1;
      else if (gnt_cnt != MAX_GNT_C)         gnt_cnt <= gnt_cnt + 4'd1;
`endif
    end
  end

  // Stage p0 -> SRAM strobe: registered on the transfer edge.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      sram_cen   <= 1'b1;
      sram_wen   <= 4'hF;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else if (xfer) begin
      sram_cen   <= 1'b0;
      sram_wen   <= sel_wen;
      sram_addr  <= sel_word;
      sram_wdata <= sel_wdata;
    end else begin
      sram_cen   <= 1'b1;
      sram_wen   <= 4'hF;
    end
  end

  logic rd_vld_p1, rd_port_p1;
  logic rd_vld_p2, rd_port_p2;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      rd_vld_p1     <= 1'b0;
      rd_port_p1    <= 1'b0;
      rd_vld_p2     <= 1'b0;
      rd_port_p2    <= 1'b0;
      bus.p0_rvalid <= 1'b0;
      bus.p1_rvalid <= 1'b0;
      bus.rdata     <= '0;
    end else begin
      // Stage p1: read tag aligned with the SRAM strobe.
      rd_vld_p1     <= xfer && !sel_write;
      rd_port_p1    <= gnt1;
      // Stage p2: tag aligned with SRAM output data.
      rd_vld_p2     <= rd_vld_p1;
      rd_port_p2    <= rd_port_p1;
      // Output stage: capture data and pulse the owning port's rvalid.
      bus.p0_rvalid <= rd_vld_p2 && !rd_port_p2;
      bus.p1_rvalid <= rd_vld_p2 && rd_port_p2;
      if (rd_vld_p2) bus.rdata <= sram_rdata;
    end
  end

endmodule

// File: tb/tb_sramc_arb.sv
// Self-checking bench for sramc_arb: table-driven per-cycle vectors plus
// hand-written sequences for arbitration ties, burst limiting and reset.
module tb_sramc_arb;
  import sramc_pkg::*;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        sram_cen;
  logic [3:0]  sram_wen;
  logic [11:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  sramc_arb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  sramc_arb #(
    .ADDR_WIDTH(32), .SRAM_ADDR_WIDTH(12), .DATA_WIDTH(32), .MAX_GNT(4)
  ) dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .bus        (bus),
    .sram_cen   (sram_cen),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Behavioural single-port SRAM: byte-masked writes, registered reads.
  logic [31:0] mem [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    sram_rdata = 32'h0;
  end
  always @(posedge hclk) begin
    if (!sram_cen) begin
      for (int b = 0; b < 4; b++)
        if (!sram_wen[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      if (&sram_wen) sram_rdata <= mem[sram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [2:0]  s0, s1;
    logic [31:0] a0, a1, d0, d1;
    logic        eg0, eg1, ecen;
    logic [3:0]  ewen;
    logic [11:0] eaddr;
    logic        erv0, erv1, crd;
    logic [31:0] erd;
  } vec_t;

  vec_t vt [16];

  task automatic drive_idle();
    bus.p0_req = 0; bus.p0_write = 0; bus.p0_size = WORD; bus.p0_addr = 0; bus.p0_wdata = 0;
    bus.p1_req = 0; bus.p1_write = 0; bus.p1_size = WORD; bus.p1_addr = 0; bus.p1_wdata = 0;
  endtask

  task automatic do_reset();
    hreset = 1'b1;
    drive_idle();
    repeat (2) @(posedge hclk);
    #1 hreset = 1'b0;
  endtask

  function automatic vec_t mk(input logic r0, r1, w0, w1, input logic [2:0] s0, s1,
                              input logic [31:0] a0, a1, d0, d1,
                              input logic eg0, eg1, ecen, input logic [3:0] ewen,
                              input logic [11:0] eaddr, input logic erv0, erv1, crd,
                              input logic [31:0] erd);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1; v.s0 = s0; v.s1 = s1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.eg0 = eg0; v.eg1 = eg1; v.ecen = ecen; v.ewen = ewen; v.eaddr = eaddr;
    v.erv0 = erv0; v.erv1 = erv1; v.crd = crd; v.erd = erd;
    return v;
  endfunction

  initial begin
    // Reset state, with both ports requesting to show grants held low.
    hreset = 1'b1;
    drive_idle();
    bus.p0_req = 1; bus.p1_req = 1;
    repeat (2) @(posedge hclk);
    #1;
    chk("rst_gnt0", {31'b0, bus.p0_gnt}, 32'd0);
    chk("rst_gnt1", {31'b0, bus.p1_gnt}, 32'd0);
    chk("rst_cen", {31'b0, sram_cen}, 32'd1);
    chk("rst_wen", {28'b0, sram_wen}, 32'hF);
    chk("rst_addr", {20'b0, sram_addr}, 32'd0);
    chk("rst_wdata", sram_wdata, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_rvalid", {30'b0, bus.p0_rvalid, bus.p1_rvalid}, 32'd0);
    drive_idle();
    hreset = 1'b0;

    //           r0 r1 w0 w1 s0    s1    a0            a1     d0            d1            g0 g1 cen wen   addr    rv0 rv1 crd rdata
    vt[0]  = mk(1, 0, 1, 0, WORD, WORD, 32'h10,       32'h0, 32'hDEADBEEF, 32'h0,        1, 0, 0, 4'h0, 12'h004, 0, 0, 0, 32'h0);
    vt[1]  = mk(1, 0, 0, 0, WORD, WORD, 32'h10,       32'h0, 32'h0,        32'h0,        1, 0, 0, 4'hF, 12'h004, 0, 0, 0, 32'h0);
    vt[2]  = mk(0, 0, 0, 0, WORD, WORD, 32'h0,        32'h0, 32'h0,        32'h0,        0, 0, 1, 4'hF, 12'h004, 0, 0, 0, 32'h0);
    vt[3]  = mk(0, 1, 0, 1, WORD, BYTE, 32'h0,        32'h1, 32'h0,        32'hAABBCCDD, 0, 1, 0, 4'hD, 12'h000, 1, 0, 1, 32'hDEADBEEF);
    vt[4]  = mk(0, 1, 0, 1, WORD, BYTE, 32'h0,        32'h2, 32'h0,        32'hAABBCCDD, 0, 1, 0, 4'hB, 12'h000, 0, 0, 0, 32'h0);
    vt[5]  = mk(0, 1, 0, 1, WORD, BYTE, 32'h0,        32'h3, 32'h0,        32'hAABBCCDD, 0, 1, 0, 4'h7, 12'h000, 0, 0, 0, 32'h0);
    vt[6]  = mk(0, 1, 0, 1, WORD, HALF, 32'h0,        32'h2, 32'h0,        32'h12345678, 0, 1, 0, 4'h3, 12'h000, 0, 0, 0, 32'h0);
    vt[7]  = mk(0, 0, 0, 0, WORD, WORD, 32'h0,        32'h0, 32'h0,        32'h0,        0, 0, 1, 4'hF, 12'h000, 0, 0, 0, 32'h0);
    vt[8]  = mk(0, 1, 0, 0, WORD, WORD, 32'h0,        32'h0, 32'h0,        32'h0,        0, 1, 0, 4'hF, 12'h000, 0, 0, 0, 32'h0);
    vt[9]  = mk(0, 0, 0, 0, WORD, WORD, 32'h0,        32'h0, 32'h0,        32'h0,        0, 0, 1, 4'hF, 12'h000, 0, 0, 0, 32'h0);
    vt[10] = mk(0, 0, 0, 0, WORD, WORD, 32'h0,        32'h0, 32'h0,        32'h0,        0, 0, 1, 4'hF, 12'h000, 0, 1, 1, 32'h1234CC00);
    vt[11] = mk(1, 0, 1, 0, HALF, WORD, 32'hFFFF3FF6, 32'h0, 32'h55667788, 32'h0,        1, 0, 0, 4'h3, 12'hFFD, 0, 0, 0, 32'h0);
    vt[12] = mk(0, 0, 0, 0, WORD, WORD, 32'h0,        32'h0, 32'h0,        32'h0,        0, 0, 1, 4'hF, 12'hFFD, 0, 0, 0, 32'h0);
    vt[13] = mk(1, 1, 1, 1, WORD, WORD, 32'hC,        32'h8, 32'h0C0C0C0C, 32'h08080808, 0, 1, 0, 4'h0, 12'h002, 0, 0, 0, 32'h0);
    vt[14] = mk(1, 0, 1, 0, WORD, WORD, 32'hC,        32'h8, 32'h0C0C0C0C, 32'h08080808, 1, 0, 0, 4'h0, 12'h003, 0, 0, 0, 32'h0);
    vt[15] = mk(0, 0, 0, 0, WORD, WORD, 32'h0,        32'h0, 32'h0,        32'h0,        0, 0, 1, 4'hF, 12'h003, 0, 0, 0, 32'h0);

    @(posedge hclk); #1;
    for (int i = 0; i < 16; i++) begin
      bus.p0_req = vt[i].r0; bus.p0_write = vt[i].w0; bus.p0_size = vt[i].s0;
      bus.p0_addr = vt[i].a0; bus.p0_wdata = vt[i].d0;
      bus.p1_req = vt[i].r1; bus.p1_write = vt[i].w1; bus.p1_size = vt[i].s1;
      bus.p1_addr = vt[i].a1; bus.p1_wdata = vt[i].d1;
      #1;
      chk($sformatf("v%0d_gnt0", i), {31'b0, bus.p0_gnt}, {31'b0, vt[i].eg0});
      chk($sformatf("v%0d_gnt1", i), {31'b0, bus.p1_gnt}, {31'b0, vt[i].eg1});
      @(posedge hclk); #1;
      chk($sformatf("v%0d_cen", i), {31'b0, sram_cen}, {31'b0, vt[i].ecen});
      chk($sformatf("v%0d_wen", i), {28'b0, sram_wen}, {28'b0, vt[i].ewen});
      chk($sformatf("v%0d_addr", i), {20'b0, sram_addr}, {20'b0, vt[i].eaddr});
      chk($sformatf("v%0d_rv0", i), {31'b0, bus.p0_rvalid}, {31'b0, vt[i].erv0});
      chk($sformatf("v%0d_rv1", i), {31'b0, bus.p1_rvalid}, {31'b0, vt[i].erv1});
      if (vt[i].crd) chk($sformatf("v%0d_rdata", i), bus.rdata, vt[i].erd);
    end
    drive_idle();

    // Tie from IDLE after reset goes to p0, the next tie to p1.
    do_reset();
    bus.p0_req = 1; bus.p0_write = 1; bus.p0_addr = 32'h40;
    bus.p1_req = 1; bus.p1_write = 1; bus.p1_addr = 32'h44;
    #1;
    chk("tie1_gnt0", {31'b0, bus.p0_gnt}, 32'd1);
    chk("tie1_gnt1", {31'b0, bus.p1_gnt}, 32'd0);
    @(posedge hclk); #1;
    bus.p0_req = 0; bus.p1_req = 0;
    @(posedge hclk); #1;
    bus.p0_req = 1; bus.p1_req = 1;
    #1;
    chk("tie2_gnt0", {31'b0, bus.p0_gnt}, 32'd0);
    chk("tie2_gnt1", {31'b0, bus.p1_gnt}, 32'd1);
    @(posedge hclk); #1;
    drive_idle();

    // Continuous contention from both ports.
    do_reset();
    bus.p0_req = 1; bus.p0_write = 1; bus.p0_addr = 32'h20;
    bus.p1_req = 1; bus.p1_write = 1; bus.p1_addr = 32'h24;
    for (int i = 0; i < 12; i++) begin
      logic exp1;
`ifdef SRAMC_ARB_BURST_LIMIT_EN
      exp1 = ((i / 4) % 2) == 1;
`else
      exp1 = 1'b0;
`endif
      #1;
      chk($sformatf("burst%0d_gnt0", i), {31'b0, bus.p0_gnt}, {31'b0, !exp1});
      chk($sformatf("burst%0d_gnt1", i), {31'b0, bus.p1_gnt}, {31'b0, exp1});
      @(posedge hclk); #1;
      chk($sformatf("burst%0d_cen", i), {31'b0, sram_cen}, 32'd0);
    end
    bus.p0_req = 0;
    #1;
    chk("release_gnt1", {31'b0, bus.p1_gnt}, 32'd1);
    @(posedge hclk); #1;
    chk("release_cen", {31'b0, sram_cen}, 32'd0);
    drive_idle();
    @(posedge hclk); #1;

    // Reset while a p0 read is in flight.
    do_reset();
    bus.p0_req = 1; bus.p0_write = 0; bus.p0_addr = 32'h10;
    #1;
    chk("inflight_gnt0", {31'b0, bus.p0_gnt}, 32'd1);
    @(posedge hclk); #1;
    hreset = 1'b1;
    #1;
    chk("inrst_gnt", {30'b0, bus.p0_gnt, bus.p1_gnt}, 32'd0);
    @(posedge hclk); #1;
    chk("midrst_cen", {31'b0, sram_cen}, 32'd1);
    chk("midrst_wen", {28'b0, sram_wen}, 32'hF);
    chk("midrst_addr", {20'b0, sram_addr}, 32'd0);
    chk("midrst_wdata", sram_wdata, 32'd0);
    chk("midrst_rdata", bus.rdata, 32'd0);
    chk("midrst_gnt", {30'b0, bus.p0_gnt, bus.p1_gnt}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midrst_rv%0d", i), {30'b0, bus.p0_rvalid, bus.p1_rvalid}, 32'd0);
      @(posedge hclk); #1;
    end
    hreset = 1'b0;
    #1;
    chk("post_rst_gnt0", {31'b0, bus.p0_gnt}, 32'd1);
    @(posedge hclk); #1;
    drive_idle();
    repeat (3) @(posedge hclk);
    #1;
    chk("post_rst_rv0", {31'b0, bus.p0_rvalid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sramc_arb.md
# sramc_arb

Two-port SRAM access arbiter for the SRAM controller. It shares the single-ported 32-bit SRAM macro between port 0 (the AHB slave path, fed by the SRAM controller's registered address/control) and port 1 (a secondary master such as DMA or an init engine). It arbitrates between the ports, decodes byte enables from transfer size, issues registered SRAM strobes and returns read data to the winning port.

## Interface
- ADDR_WIDTH, 32, requester byte-address width
- SRAM_ADDR_WIDTH, 12, SRAM word-address width
- DATA_WIDTH, 32, data width; fixed at 32, four byte lanes
- MAX_GNT, 4, maximum consecutive transfers granted to one port while the other port waits (legal range 1..15)
- hclk  in  1  clock; all logic on its rising edge
- hreset  in  1  reset, synchronous, active-high
- p0_req / p1_req  in  1  access request, held with fields stable until granted
- p0_write / p1_write  in  1  1 = write, 0 = read
- p0_size / p1_size  in  3  HSIZE encoding
- p0_addr / p1_addr  in  ADDR_WIDTH  byte address
- p0_wdata / p1_wdata  in  DATA_WIDTH  write data
- p0_gnt / p1_gnt  out  1  combinational grant; a transfer occurs on the edge where req && gnt
- sram_cen  out  1  chip enable, active-low, registered
- sram_wen  out  4  byte write enables, active-low, registered
- sram_addr  out  SRAM_ADDR_WIDTH  word address, registered
- sram_wdata  out  DATA_WIDTH  write data, registered
- sram_rdata  in  DATA_WIDTH  SRAM read data, valid in the cycle after a read strobe
- rdata  out  DATA_WIDTH  registered read data
- p0_rvalid / p1_rvalid  out  1  one-cycle pulse marking rdata valid for that port

## Operation
- States: IDLE, OWN0, OWN1. Registers: `last_owner` (reset value 1, so p0 wins first), `gnt_cnt` (4 bits).
- Grant selection, at most one grant per cycle:
  - From IDLE with both ports requesting, the port that is not `last_owner` wins.
  - In OWNx, port x keeps the grant while it requests, unless `gnt_cnt == MAX_GNT` and the other port requests; then the other port is granted.
  - If the owner drops its request and the other port requests, the other port wins immediately.
- Transitions:
  - IDLE→OWNx on a grant to x.
  - OWNx→OWNy on a switch.
  - Any state→IDLE on an edge with no grant.
  - `last_owner` updates on every transfer.
- `gnt_cnt`:
  - Set to 1 on the first transfer after IDLE or after a switch.
  - Incremented on each consecutive transfer to the same owner; saturates at MAX_GNT.
  - Cleared in IDLE.
- Address and data: `sram_addr = addr[SRAM_ADDR_WIDTH+1:2]`; upper address bits are ignored.
- Write-enable decode (writes only; reads drive `sram_wen = 4'hF`). `en` below is the active-high enable; `sram_wen = ~en`.
  - size 0: `en = 4'b0001 << addr[1:0]`
  - size 1: `en = addr[1] ? 4'b1100 : 4'b0011`
  - size ≥ 2: `en = 4'b1111`
  - No error response; misaligned low address bits are ignored.
- Read return: only port-tagged reads raise rvalid. Writes never pulse rvalid.

## Timing
- Transfer edge T (req && gnt): `sram_cen = 0`, address, wen and wdata are valid from T to T+1. `sram_cen` returns to 1 at T+1 unless another transfer occurs at T+1.
- Throughput: one transfer per cycle, with no bubble on an owner switch.
- Read latency: SRAM data is present during T+1..T+2. It is captured into `rdata` at T+2, and `px_rvalid` is high during T+2..T+3. Back-to-back reads give back-to-back rvalid pulses in issue order.
- Reset values:
  - `sram_cen = 1`, `sram_wen = 4'hF`, `sram_addr = 0`, `sram_wdata = 0`, `rdata = 0`, both rvalid 0.
  - State IDLE, `gnt_cnt = 0`, `last_owner = 1`.
  - Both gnt outputs are forced 0 while hreset = 1.
- Reset mid-operation: a read in flight at the reset edge produces no rvalid. Requests are re-arbitrated from the post-reset state.

## Configuration
- SRAMC_ARB_BURST_LIMIT_EN defined: the MAX_GNT limit and `gnt_cnt` are implemented as described.
- Not defined: `gnt_cnt` is removed and the owner keeps the grant for as long as it requests, so AHB bursts are never split. The other port is served only once the owner releases.

## Structure
- Shared package `sramc_pkg`: arbiter state encoding (IDLE/OWN0/OWN1) and HSIZE constants (BYTE = 3'b000, HALF = 3'b001, WORD = 3'b010), shared with the SRAM controller.
- Sub-module `sramc_wen_dec`: combinational size/addr[1:0]/write → 4-bit active-low wen. Instantiated once, on the selected port's fields.

## Test plan
- Reset, then p0 word write to 0x0000_0010 with data 0xDEADBEEF, followed by a read of the same address. Expected: `sram_addr = 4`, `sram_wen = 4'h0`; the read gives `rdata = 0xDEADBEEF` with `p0_rvalid` exactly two edges after the read transfer.
- p1 byte writes at addresses 0x1..0x3 → `sram_wen` = 4'b1101, 4'b1011, 4'b0111. p1 halfword write at 0x2 → `sram_wen = 4'b0011`.
- p0 and p1 request simultaneously from IDLE after reset. Expected: p0 granted first. After both go idle, a second simultaneous request grants p1.
- With the macro defined, MAX_GNT = 4, and p0 and p1 requesting continuously: grant pattern is p0×4, p1×4, p0×4, with `sram_cen` low every cycle. Without the macro, p0 keeps the grant until `p0_req` drops.
- p0 read issued, hreset asserted on the next edge → no `p0_rvalid`. All outputs are at reset values one edge later, and gnt is 0 while reset is held.
